// File: rtl/cac_uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side byte stream bundle for the CAC TX arbiter.
// Latency: none (wires only).
// Backpressure: tx_ready propagates to the granted requester's req_ready.
interface cac_uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;

    // Environment side: requesters and UART transmitter
    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/cac_uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UART TX among NUM_REQ byte streams.
// Latency: grant 1 cycle after request (2 with source tag); data path is a pure mux.
// Backpressure: tx_ready passes straight to the owner's req_ready; stalled owners time out.
// Optional source tag byte before each frame: define CAC_TX_ARB_SRC_TAG_EN.
module cac_uart_tx_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter int          DATA_WIDTH     = 8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  SRC_TAG_BASE   = 8'hA0
) (
    input  logic                   clk,
    input  logic                   rst,
    cac_uart_tx_arbiter_if.slave   bus,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef CAC_TX_ARB_SRC_TAG_EN
        TAG  = 2'd2,
`endif
        XFER = 2'd1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  rr_q, rr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tout_q, tout_d;

    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  pick_vld;
    logic [2:0]            pick_idx;
    logic [2:0]            rr_next;

    // Mux the current owner's stream onto internal select signals
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                sel_vld  = bus.req_valid[i];
                sel_last = bus.req_last[i];
                sel_dat  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search: first valid requester at or above rr_q, wrapping
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_vld && bus.req_valid[i] &&
                    ((int'(rr_q) + off == i) || (int'(rr_q) + off == i + NUM_REQ))) begin
                    pick_vld = 1'b1;
                    pick_idx = 3'(i);
                end
            end
        end
    end

    assign rr_next = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

    // Next-state, timeout counter and stream outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cnt_d         = '0;
        tout_d        = 1'b0;
        bus.req_ready = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
`ifdef CAC_TX_ARB_SRC_TAG_EN
                    state_d = TAG;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef CAC_TX_ARB_SRC_TAG_EN
            TAG: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = DATA_WIDTH'(SRC_TAG_BASE) | DATA_WIDTH'(grant_q);
                if (bus.tx_ready) begin
                    state_d = XFER;
                end
            end
`endif
            XFER: begin
                bus.tx_valid = sel_vld;
                bus.tx_data  = sel_dat;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == 3'(i)) begin
                        bus.req_ready[i] = bus.tx_ready;
                    end
                end
                if (sel_vld && bus.tx_ready) begin
                    if (sel_last) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end
                end else if (!sel_vld) begin
                    // Owner stalled mid-frame: count idle cycles towards forced release
                    cnt_d = cnt_q + 16'd1;
                    if ((TIMEOUT_CYCLES != 16'd0) && (cnt_d == TIMEOUT_CYCLES)) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                        tout_d  = 1'b1;
                    end
                end else begin
                    // Byte offered but TX busy: the owner is not stalling, hold the count
                    cnt_d = cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // A frame aborted by reset must not have its byte accepted in the reset cycle
        if (rst) begin
            bus.req_ready = '0;
            bus.tx_valid  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign timeout_pulse = tout_q;

endmodule

// File: doc/cac_uart_tx_arbiter.md
# cac_uart_tx_arbiter

Frame-level round-robin arbiter that shares the single communication-and-control UART transmitter among several internal byte-stream sources (command responses, status reporter, error logger, debug echo). It sits between the requesters and the UART TX byte interface. It grants one requester at a time for a whole frame, terminated by that requester's `last` flag, and recovers from requesters that stall mid-frame.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: byte width of the stream.
- `TIMEOUT_CYCLES`, 16'd50000: idle cycles allowed mid-frame before forced release. 0 disables the timeout.
- `SRC_TAG_BASE`, 8'hA0: upper bits of the source tag byte (used only with the tag macro).

Ports:
- `clk`, in, 1: system clock, single domain.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: requester i has a byte on `req_data`.
- `req_data`, in, NUM_REQ*DATA_WIDTH: byte of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`, in, NUM_REQ: the current byte is the final byte of the frame.
- `req_ready`, out, NUM_REQ: the byte of requester i is accepted this cycle.
- `tx_data`, out, DATA_WIDTH: byte to the UART transmitter.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: the UART transmitter accepts the byte (an idle TX can accept).
- `grant_id`, out, 3: index of the current owner. It holds the last owner when idle.
- `busy`, out, 1: a frame is in progress.
- `timeout_pulse`, out, 1: one-cycle pulse when a grant is forcibly released.

## Operation
- States: IDLE, TAG (present only with the macro), XFER.
- IDLE:
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise select the first set bit, searching round-robin from `rr_ptr` upward with wrap-around.
  - Register it into `grant_id` and go to TAG (macro enabled) or XFER.
  - `rr_ptr` resets to 0, so requester 0 has the highest priority after reset.
- XFER:
  - `tx_valid` = `req_valid[grant_id]` and `tx_data` = the granted byte.
  - `req_ready[grant_id]` = `tx_ready`. All other `req_ready` bits are 0.
  - A transfer happens when tx_valid and tx_ready are both high. A transfer with `req_last` set ends the frame: go to IDLE next cycle and set `rr_ptr` = `grant_id`+1 (mod NUM_REQ).
- Timeout:
  - A 16-bit counter runs in XFER while `req_valid[grant_id]` is low.
  - It clears on any transfer and on leaving XFER.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), pulse `timeout_pulse`, go to IDLE, and advance `rr_ptr` as for a normal end of frame. The requester's remaining bytes become a new frame that must re-arbitrate.
- Requests are sampled only in IDLE. A requester that drops `req_valid` before being granted loses nothing and has no pending state.
- Simultaneous requests: exactly one is granted. The others wait at least until the end of the frame.
- Single-byte frame (valid and last together): legal, one transfer.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - `req_ready`=0, `tx_valid`=0, `tx_data`=0.
  - `grant_id`=0, `busy`=0, `timeout_pulse`=0.
  - `rr_ptr`=0, state IDLE, timeout counter 0.
- Reset asserted mid-frame aborts the frame at once. The next cycle shows reset values and the requester's byte is not accepted.
- Arbitration latency: `req_valid` high in IDLE at cycle N gives `busy`=1 and the first byte offered at N+1 (no tag) or N+2 (tag).
- Between frames there is exactly one IDLE bubble cycle: last transfer at N, IDLE at N+1, next grant effective at N+2.
- The data path is combinational in XFER (mux only): zero-cycle latency from requester to `tx_*`, and from `tx_ready` to `req_ready`.
- `timeout_pulse` is asserted in the cycle the state returns to IDLE.

## Configuration
- Macro: `CAC_TX_ARB_SRC_TAG_EN`.
- Defined:
  - After each grant, the TAG state drives `tx_valid`=1 and `tx_data`=`SRC_TAG_BASE` | `grant_id`, with every `req_ready` at 0.
  - On `tx_ready`, go to XFER.
  - The timeout counter does not run in TAG.
- Undefined: the TAG state does not exist, IDLE goes straight to XFER, and frames are passed through untagged.

## Test plan
- Reset, then requester 2 sends 3 bytes 0x10, 0x01, 0x11 (last on 0x11) with `tx_ready` always 1. Required: `tx_data` shows those bytes on consecutive cycles, `grant_id`=2, and `busy` drops one cycle after 0x11.
- Requesters 0 and 1 each hold a 2-byte frame from the same cycle. Required: frame 0 completes first, then one bubble cycle, then frame 1. The bytes of the two frames never interleave.
- Requesters 0, 1 and 3 all request continuously with 1-byte frames. Required: grant order 0, 1, 3, 0, 1, 3.
- `TIMEOUT_CYCLES`=8: requester 1 sends 0x30 without last, then drops valid. Required: `timeout_pulse` 8 cycles after the 0x30 transfer, then return to IDLE with requester 2 next in priority.
- `tx_ready` held low for 5 cycles mid-frame. Required: `tx_valid`, `tx_data` and `grant_id` stay stable, `req_ready` stays 0, and no timeout fires.
- With `CAC_TX_ARB_SRC_TAG_EN` defined and `SRC_TAG_BASE`=8'hA0, requester 3 sends 0x55 with last. Required: the bytes out are 0xA3 then 0x55.
